// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predictor: branch func3 codes, 2-bit
// counter encodings and the saturating counter update.
package branch_predict_unit_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } func3_e;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Saturating step: toward CTR_ST on taken, toward CTR_SNT on not taken.
    function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        case (cur)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Resolution bus between the execute stage (master) and the predictor (slave).
interface branch_predict_unit_if #(
    parameter int XLEN = 32
);
    logic            res_valid;
    logic [XLEN-1:0] res_pc;
    logic [2:0]      res_func3;
    logic            cf;
    logic            zf;
    logic            vf;
    logic            sf;
    logic            res_pred_taken;
    logic [XLEN-1:0] res_target;
    logic            out_valid;
    logic            out_taken;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect_pc;

    modport master (
        output res_valid, res_pc, res_func3, cf, zf, vf, sf, res_pred_taken, res_target,
        input  out_valid, out_taken, out_mispredict, out_redirect_pc
    );

    modport slave (
        input  res_valid, res_pc, res_func3, cf, zf, vf, sf, res_pred_taken, res_target,
        output out_valid, out_taken, out_mispredict, out_redirect_pc
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Evaluates a conditional branch outcome from func3 and the rs1 - rs2 flags.
module branch_cond_eval
    import branch_predict_unit_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       cf,
    input  logic       zf,
    input  logic       vf,
    input  logic       sf,
    output logic       taken,
    output logic       legal
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        taken = 1'b0;
        legal = 1'b1;
        case (func3_e'(func3))
            F3_BEQ:  taken = zf;
            F3_BNE:  taken = ~zf;
            F3_BLT:  taken = (sf != vf);
            F3_BGE:  taken = (sf == vf);
            F3_BLTU: taken = ~cf;
            F3_BGEU: taken = cf;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit counter table, one-cycle resolution stage
// and saturating branch/mispredict statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      pred_pc,
    output logic                 pred_taken,
    branch_predict_unit_if.slave bus,
    output logic [CNT_W-1:0]     stat_branches,
    output logic [CNT_W-1:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    ctr_e             bht [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             taken;
    logic             legal;
    logic             accept;
    logic             mispredict;
    logic             unused_pc_bits;

    branch_cond_eval u_cond (
        .func3 (bus.res_func3),
        .cf    (bus.cf),
        .zf    (bus.zf),
        .vf    (bus.vf),
        .sf    (bus.sf),
        .taken (taken),
        .legal (legal)
    );

    assign pred_idx       = pred_pc[IDX_W+1:2];
    assign res_idx        = bus.res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc, bus.res_pc};

    // Table read is the registered value, so a same-cycle update is not visible yet.
    assign pred_taken = bht[pred_idx][1];

    assign accept     = bus.res_valid && legal;
    assign mispredict = taken ^ bus.res_pred_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is reset explicitly; it is small flop storage, not a RAM macro.
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_WNT;
            end
        end else if (accept) begin
            bht[res_idx] <= ctr_next(bht[res_idx], taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            bus.out_valid       <= 1'b0;
            bus.out_taken       <= 1'b0;
            bus.out_mispredict  <= 1'b0;
            bus.out_redirect_pc <= '0;
        end else begin
            bus.out_valid       <= bus.res_valid;
            bus.out_taken       <= accept && taken;
            bus.out_mispredict  <= accept && mispredict;
            bus.out_redirect_pc <= taken ? bus.res_target : bus.res_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (accept) begin
            if (stat_branches != '1) begin
                stat_branches <= stat_branches + CNT_W'(1);
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: expected resolutions are queued
// when a branch is driven and compared one cycle later.
module tb_branch_predict_unit;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    typedef struct {
        string       name;
        logic        taken;
        logic        mis;
        logic [31:0] redir;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [XLEN-1:0]   pred_pc;
    logic              pred_taken;
    logic [CNT_W-1:0]  stat_branches;
    logic [CNT_W-1:0]  stat_mispredicts;

    branch_predict_unit_if #(.XLEN(XLEN)) bus ();

    branch_predict_unit #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (ENTRIES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .bus              (bus.slave),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   model_br = 0;
    int   model_mis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // flags = {cf, zf, vf, sf}
    task automatic drive(input string name, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [3:0] flags, input logic pred, input logic [31:0] target,
                         input logic exp_taken, input logic exp_mis, input logic [31:0] exp_redir,
                         input logic exp_legal);
        exp_t e;
        bus.res_valid      = 1'b1;
        bus.res_pc         = pc;
        bus.res_func3      = f3;
        {bus.cf, bus.zf, bus.vf, bus.sf} = flags;
        bus.res_pred_taken = pred;
        bus.res_target     = target;
        e.name  = name;
        e.taken = exp_taken;
        e.mis   = exp_mis;
        e.redir = exp_redir;
        sb.push_back(e);
        if (exp_legal) begin
            if (model_br < CNT_MAX) model_br++;
            if (exp_mis && model_mis < CNT_MAX) model_mis++;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s out_valid: got %b expected 1", e.name, bus.out_valid);
            end
            checks++;
            if (bus.out_taken !== e.taken) begin
                errors++;
                $display("FAIL %s out_taken: got %b expected %b", e.name, bus.out_taken, e.taken);
            end
            checks++;
            if (bus.out_mispredict !== e.mis) begin
                errors++;
                $display("FAIL %s out_mispredict: got %b expected %b", e.name, bus.out_mispredict, e.mis);
            end
            if (e.mis) begin
                checks++;
                if (bus.out_redirect_pc !== e.redir) begin
                    errors++;
                    $display("FAIL %s out_redirect_pc: got %h expected %h", e.name, bus.out_redirect_pc, e.redir);
                end
            end
        end else begin
            checks++;
            if ({bus.out_valid, bus.out_taken, bus.out_mispredict} !== 3'b000) begin
                errors++;
                $display("FAIL idle outputs: got v/t/m %b%b%b expected 000",
                         bus.out_valid, bus.out_taken, bus.out_mispredict);
            end
        end
        checks++;
        if (stat_branches !== CNT_W'(model_br)) begin
            errors++;
            $display("FAIL stat_branches: got %0d expected %0d", stat_branches, model_br);
        end
        checks++;
        if (stat_mispredicts !== CNT_W'(model_mis)) begin
            errors++;
            $display("FAIL stat_mispredicts: got %0d expected %0d", stat_mispredicts, model_mis);
        end
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        checks++;
        if (pred_taken !== exp) begin
            errors++;
            $display("FAIL %s pred_taken@%h: got %b expected %b", name, pc, pred_taken, exp);
        end
    endtask

    // Optionally presents a mispredicting branch during the reset edge; it must be dropped.
    task automatic do_reset(input logic with_branch);
        if (with_branch) begin
            bus.res_valid      = 1'b1;
            bus.res_pc         = 32'h100;
            bus.res_func3      = 3'b000;
            {bus.cf, bus.zf, bus.vf, bus.sf} = 4'b0100;
            bus.res_pred_taken = 1'b0;
            bus.res_target     = 32'h200;
        end
        rst = 1'b1;
        sb.delete();
        model_br  = 0;
        model_mis = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.res_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_taken, bus.out_mispredict} !== 3'b000 || bus.out_redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset outputs: got v/t/m %b%b%b pc %h expected 000 pc 0",
                     bus.out_valid, bus.out_taken, bus.out_mispredict, bus.out_redirect_pc);
        end
        checks++;
        if (stat_branches !== '0 || stat_mispredicts !== '0) begin
            errors++;
            $display("FAIL reset stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        check_pred("reset_0x100", 32'h100, 1'b0);
        for (int i = 0; i < ENTRIES; i++) begin
            check_pred("reset_entry", 32'(i * 4), 1'b0);
        end
    endtask

    task automatic test_beq_train();
        do_reset(1'b0);
        drive("beq1", 32'h100, 3'b000, 4'b0100, 1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1);
        tick();
        check_pred("beq_after1", 32'h100, 1'b1);
        drive("beq2", 32'h100, 3'b000, 4'b0100, 1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1);
        tick();
        check_pred("beq_after2", 32'h100, 1'b1);
        drive("beq3", 32'h100, 3'b000, 4'b0100, 1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1);
        tick();
        // Counter is 11: one not-taken leaves it predicting taken, a second does not.
        drive("beq_nt1", 32'h100, 3'b000, 4'b0000, 1'b0, 32'h200, 1'b0, 1'b0, 32'h104, 1'b1);
        tick();
        check_pred("ctr_sat_11", 32'h100, 1'b1);
        check_pred("alias_0x143", 32'h143, 1'b1);
        drive("beq_nt2", 32'h100, 3'b000, 4'b0000, 1'b1, 32'h200, 1'b0, 1'b1, 32'h104, 1'b1);
        tick();
        check_pred("ctr_back_01", 32'h100, 1'b0);
    endtask

    task automatic test_bltu();
        do_reset(1'b0);
        drive("bltu_cf1", 32'h40, 3'b110, 4'b1000, 1'b1, 32'h80, 1'b0, 1'b1, 32'h44, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_illegal();
        do_reset(1'b0);
        drive("illegal_010", 32'h100, 3'b010, 4'b0100, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check_pred("illegal_010_ctr", 32'h100, 1'b0);
        drive("illegal_011", 32'h100, 3'b011, 4'b0100, 1'b0, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check_pred("illegal_011_ctr", 32'h100, 1'b0);
        checks++;
        if (stat_branches !== '0) begin
            errors++;
            $display("FAIL illegal stat_branches: got %0d expected 0", stat_branches);
        end
    endtask

    task automatic test_same_cycle();
        do_reset(1'b0);
        pred_pc = 32'h100;
        drive("rbw", 32'h100, 3'b000, 4'b0100, 1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b1);
        check_pred("rbw_pre", 32'h100, 1'b0);
        tick();
        check_pred("rbw_post", 32'h100, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_reset(1'b0);
        drive("blt_lt",   32'h200, 3'b100, 4'b0001, 1'b0, 32'h300, 1'b1, 1'b1, 32'h300, 1'b1); tick();
        drive("blt_ge",   32'h204, 3'b100, 4'b0011, 1'b0, 32'h300, 1'b0, 1'b0, 32'h208, 1'b1); tick();
        drive("bge_ge",   32'h208, 3'b101, 4'b0000, 1'b0, 32'h400, 1'b1, 1'b1, 32'h400, 1'b1); tick();
        drive("bge_lt",   32'h20c, 3'b101, 4'b0001, 1'b1, 32'h400, 1'b0, 1'b1, 32'h210, 1'b1); tick();
        drive("bne_ne",   32'h210, 3'b001, 4'b0000, 1'b0, 32'h500, 1'b1, 1'b1, 32'h500, 1'b1); tick();
        drive("bltu_cf0", 32'h214, 3'b110, 4'b0000, 1'b0, 32'h600, 1'b1, 1'b1, 32'h600, 1'b1); tick();
        drive("bgeu_cf0", 32'h218, 3'b111, 4'b0000, 1'b1, 32'h700, 1'b0, 1'b1, 32'h21c, 1'b1); tick();
        drive("bgeu_cf1", 32'h21c, 3'b111, 4'b1000, 1'b1, 32'h700, 1'b1, 1'b0, 32'h700, 1'b1); tick();
        drive("wrap_pc4", 32'hffff_fffc, 3'b101, 4'b0001, 1'b1, 32'h800, 1'b0, 1'b1, 32'h0, 1'b1); tick();
        tick();
    endtask

    task automatic test_stat_saturate();
        do_reset(1'b0);
        for (int i = 0; i < 20; i++) begin
            drive("sat_bne", 32'h1000 + 32'(i * 4), 3'b001, 4'b0000, 1'b0, 32'h2000,
                  1'b1, 1'b1, 32'h2000, 1'b1);
            tick();
        end
        checks++;
        if (stat_branches !== 4'd15 || stat_mispredicts !== 4'd15) begin
            errors++;
            $display("FAIL stat_saturate: got %0d/%0d expected 15/15", stat_branches, stat_mispredicts);
        end
        do_reset(1'b1);
        check_pred("rst_drop_ctr", 32'h100, 1'b0);
    endtask

    initial begin
        rst                = 1'b1;
        pred_pc            = '0;
        bus.res_valid      = 1'b0;
        bus.res_pc         = '0;
        bus.res_func3      = '0;
        bus.cf             = 1'b0;
        bus.zf             = 1'b0;
        bus.vf             = 1'b0;
        bus.sf             = 1'b0;
        bus.res_pred_taken = 1'b0;
        bus.res_target     = '0;
        test_reset();
        test_beq_train();
        test_bltu();
        test_illegal();
        test_same_cycle();
        test_back_to_back();
        test_stat_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, 32, width of PC and branch target.
REQ-002 Parameter BHT_ENTRIES, 16, number of 2-bit counters; SHALL be a power of two, at least 2.
REQ-003 Parameter CNT_W, 16, width of each statistics counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 pred_pc  input  XLEN  fetch-stage PC to predict.
REQ-007 pred_taken  output  1  combinational prediction for pred_pc.
REQ-008 res_valid  input  1  execute stage presents a conditional branch this cycle.
REQ-009 res_pc  input  XLEN  PC of the resolving branch.
REQ-010 res_func3  input  3  branch func3.
REQ-011 cf, zf, vf, sf  input  1 each  ALU flags from rs1 - rs2, computed as rs1 + ~rs2 + 1; cf=1 means no borrow.
REQ-012 res_pred_taken  input  1  prediction made for this branch at fetch.
REQ-013 res_target  input  XLEN  taken target.
REQ-014 out_valid  output  1  registered resolution result is valid.
REQ-015 out_taken  output  1  registered actual outcome.
REQ-016 out_mispredict  output  1  registered misprediction flag.
REQ-017 out_redirect_pc  output  XLEN  registered correct next PC; valid only when out_mispredict=1.
REQ-018 stat_branches, stat_mispredicts  output  CNT_W each  statistics counters.

Function
REQ-019 Index SHALL be PC[log2(BHT_ENTRIES)+1:2]; bits [1:0] are ignored.
REQ-020 pred_taken SHALL equal bit 1 of the counter at the pred_pc index (10 and 11 predict taken).
REQ-021 Outcome encoding: BEQ 000 -> zf; BNE 001 -> ~zf; BLT 100 -> sf!=vf; BGE 101 -> sf==vf; BLTU 110 -> ~cf; BGEU 111 -> cf.
REQ-022 func3 010 or 011 with res_valid=1 SHALL be treated as illegal: no counter or statistics update; next cycle out_valid=1, out_taken=0, out_mispredict=0.
REQ-023 Resolution latency SHALL be one cycle: outputs for a res_valid cycle appear in the following cycle.
REQ-024 out_valid SHALL be 0 in any cycle not following a res_valid cycle; out_taken and out_mispredict SHALL also be 0 in that cycle.
REQ-025 out_mispredict SHALL equal out_taken XOR the registered res_pred_taken.
REQ-026 out_redirect_pc SHALL be res_target when the branch is taken, otherwise res_pc+4 (modulo 2^XLEN).
REQ-027 On a legal res_valid, the counter at the res_pc index SHALL saturate: if taken, increment, holding at 11; if not taken, decrement, holding at 00.
REQ-028 Predict and update on the same index in the same cycle: pred_taken SHALL reflect the pre-update value (read-before-write).
REQ-029 stat_branches SHALL increment on each legal res_valid; stat_mispredicts SHALL increment when that branch mispredicts; both SHALL saturate at all-ones and not wrap.
REQ-030 res_valid=1 in consecutive cycles SHALL be accepted every cycle with no stall; there is no backpressure.

Reset
REQ-031 With rst=1 at a clock edge, all counters SHALL load 01 (weakly not-taken).
REQ-032 With rst=1 at a clock edge, out_valid, out_taken, out_mispredict, out_redirect_pc and both statistics counters SHALL load 0.
REQ-033 rst=1 SHALL take priority over a simultaneous res_valid, and that branch SHALL be discarded.

Structure
REQ-034 The func3 codes and the counter encodings (00, 01, 10, 11) SHALL live in the shared defines package.
REQ-035 Outcome evaluation SHALL be a combinational sub-module, branch_cond_eval, with inputs func3 and the four flags and outputs taken and legal.

Verification
REQ-036 Reset, then pred_pc=0x100 -> pred_taken=0; stat_branches=0.
REQ-037 Three taken BEQ (zf=1) at res_pc=0x100 with res_pred_taken=0, target 0x200 -> first out_mispredict=1, redirect 0x200; pred_taken=1 after the second; counter=11 after the third.
REQ-038 BLTU with cf=1 at res_pc=0x40, res_pred_taken=1 -> out_taken=0, out_mispredict=1, redirect 0x44.
REQ-039 res_valid with func3=010 -> out_valid=1, out_mispredict=0; counters and statistics unchanged.
REQ-040 pred_pc=res_pc=0x100 with counter 01, taken update in the same cycle -> pred_taken=0 that cycle and 1 the next.
REQ-041 CNT_W=4, 20 mispredicting branches -> both statistics counters hold at 15; rst mid-stream clears them to 0 and out_valid=0.
